// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver that assembles left/right words and publishes them as an aligned pair
module i2s_rx #(
  parameter int DELAY = 1
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        lrclk,
  input  logic        sdata,
  output logic [31:0] left_chan,
  output logic [31:0] right_chan,
  output logic        valid,
  output logic [5:0]  word_len,
  output logic        frame_err,
  output logic        ovf
);
  typedef enum logic {UNSYNC, RUN} state_t;
  state_t state, state_n;
  logic lrclk_q, lr_edge, full, ovf_set, left_done, right_done, emit;
  logic lhold_ok, pend, p_err;
  logic [31:0] sr, bit_word, done_word, hold, p_left, p_right;
  logic [5:0] cnt, bit_cnt, done_cnt, hcnt, p_cnt;
  // decode the word boundary and the word/count that completes on it
  always_comb begin
    lr_edge = lrclk != lrclk_q;
    full = cnt == 6'd32;
    bit_word = full ? sr : sr | ({sdata, 31'b0} >> cnt);
    bit_cnt = full ? cnt : cnt + 6'd1;
    done_word = (DELAY == 1) ? bit_word : sr;
    done_cnt = (DELAY == 1) ? bit_cnt : cnt;
    ovf_set = full && (!lr_edge || DELAY == 1);
    left_done = lr_edge && !lrclk_q;
    right_done = lr_edge && lrclk_q;
    emit = state == RUN && right_done && lhold_ok;
    state_n = right_done ? RUN : state;
  end
  // sync state: the first completed right word marks a known frame boundary
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) state <= UNSYNC;
    else state <= state_n;
  end
  // shift register, left holding stage and the one-cycle publish pipeline
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      lrclk_q <= 1'b1;
      sr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      hold <= '0;
      hcnt <= '0;
      lhold_ok <= 1'b0;
      pend <= 1'b0;
      p_left <= '0;
      p_right <= '0;
      p_cnt <= '0;
      p_err <= 1'b0;
      valid <= 1'b0;
      frame_err <= 1'b0;
      left_chan <= '0;
      right_chan <= '0;
      word_len <= '0;
    end else begin
      lrclk_q <= lrclk;
      sr <= lr_edge ? ((DELAY == 1) ? 32'd0 : {sdata, 31'b0}) : bit_word;
      cnt <= lr_edge ? ((DELAY == 1) ? 6'd0 : 6'd1) : bit_cnt;
      ovf <= ovf | ovf_set;
      if (state == RUN && left_done) begin
        hold <= done_word;
        hcnt <= done_cnt;
        lhold_ok <= 1'b1;
      end
      if (emit) begin
        p_left <= hold;
        p_right <= done_word;
        p_cnt <= done_cnt;
        p_err <= hcnt != done_cnt;
        lhold_ok <= 1'b0;
      end
      pend <= emit;
      valid <= pend;
      frame_err <= pend && p_err;
      if (pend) begin
        left_chan <= p_left;
        right_chan <= p_right;
        word_len <= p_cnt;
      end
    end
  end
endmodule
